// File: rtl/sha256_pkg.sv
// Constants and padder state encoding shared between the SHA-256 padder and hash core.
package sha256_pkg;
  localparam int         BLOCK_W      = 512;
  localparam int         LEN_W        = 64;
  localparam logic [7:0] PAD_BYTE     = 8'h80;
  localparam int         LEN_BYTE_POS = 56;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EMIT   = 2'd1,
    EXTRA  = 2'd2
  } padder_state_e;
endpackage

// File: rtl/sha256_padder.sv
// Byte-stream to 512-bit block padder for SHA-256: appends 0x80, zero fill and
// 64-bit big-endian bit length, spilling into an extra block when needed.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [0:BLOCK_W-1] blk_data,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               blk_first,
  output logic               blk_last
);
  padder_state_e      state_q, state_d;
  logic [0:BLOCK_W-1] buf_q, buf_d;
  logic [5:0]         pos_q, pos_d;
  logic [60:0]        len_q, len_d;
  logic               pend_q, pend_d;
  logic               pad80_q, pad80_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [LEN_W-1:0]   bits_len;
  logic [6:0]         n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACCEPT;
      buf_q   <= '0;
      pos_q   <= '0;
      len_q   <= '0;
      pend_q  <= 1'b0;
      pad80_q <= 1'b0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      pend_q  <= pend_d;
      pad80_q <= pad80_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = rst && (state_q == ACCEPT);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = buf_q;
  assign blk_first = first_q;
  assign blk_last  = last_q;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    pos_d    = pos_q;
    len_d    = len_q;
    pend_d   = pend_q;
    pad80_d  = pad80_q;
    first_d  = first_q;
    last_d   = last_q;
    bits_len = {len_q, 3'b000};
    n        = 7'(pos_q) + 7'd1;
    unique case (state_q)
      ACCEPT: if (in_valid) begin
        buf_d[{pos_q, 3'b000} +: 8] = in_data;
        pos_d    = pos_q + 6'd1;
        len_d    = len_q + 61'd1;
        bits_len = {len_d, 3'b000};
        if (in_last) begin
          // Bytes past the data may hold a previous block; rewrite all of them.
          for (int j = 0; j < 64; j++) begin
            if (7'(j) == n)     buf_d[j*8 +: 8] = PAD_BYTE;
            else if (7'(j) > n) buf_d[j*8 +: 8] = 8'h00;
            if (n <= 7'(LEN_BYTE_POS - 1) && j >= LEN_BYTE_POS)
              buf_d[j*8 +: 8] = bits_len[(63-j)*8 +: 8];
          end
          pend_d  = (n > 7'(LEN_BYTE_POS - 1));
          pad80_d = (n == 7'd64);
          last_d  = (n <= 7'(LEN_BYTE_POS - 1));
          state_d = EMIT;
        end else if (pos_q == 6'd63) begin
          last_d  = 1'b0;
          state_d = EMIT;
        end
      end
      EMIT: if (blk_ready) begin
        first_d = last_q;
        if (pend_q) begin
          state_d = EXTRA;
        end else begin
          state_d = ACCEPT;
          pos_d   = '0;
          if (last_q) len_d = '0;
        end
      end
      EXTRA: begin
        buf_d = '0;
        if (pad80_q) buf_d[0 +: 8] = PAD_BYTE;
        for (int j = LEN_BYTE_POS; j < 64; j++)
          buf_d[j*8 +: 8] = bits_len[(63-j)*8 +: 8];
        last_d  = 1'b1;
        pend_d  = 1'b0;
        pad80_d = 1'b0;
        state_d = EMIT;
      end
      default: state_d = ACCEPT;
    endcase
  end
endmodule

// File: tb/tb_sha256_padder.sv
// Random/directed bench for sha256_padder against a byte-queue padding model.
module tb_sha256_padder;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid, in_last, in_ready;
  logic [0:511] blk_data;
  logic         blk_valid, blk_ready, blk_first, blk_last;

  int total = 0;
  int bad   = 0;

  logic [7:0]   msg_q[$];
  logic [0:511] exp_blk[$];
  logic         exp_first[$];
  logic         exp_last[$];

  sha256_padder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Padded message = msg ++ 0x80 ++ zeros ++ 64-bit BE bit length, cut in 64-byte blocks.
  task automatic build_exp();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [0:511] b;
    int           nb;
    exp_blk.delete(); exp_first.delete(); exp_last.delete();
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg_q.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[k*8 +: 8]);
    nb = p.size() / 64;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 64; j++) b[j*8 +: 8] = p[i*64 + j];
      exp_blk.push_back(b);
      exp_first.push_back(i == 0);
      exp_last.push_back(i == nb - 1);
    end
  endtask

  // mode 0: ready always high; 1: random ready/valid; 2: stall 5 EMIT cycles
  task automatic run_msg(input int mode);
    int   idx, got, cyc, cd, stall;
    logic bx, kx;
    build_exp();
    idx = 0; got = 0; cyc = 0; cd = 0; stall = 0;
    while (got < exp_blk.size() && cyc < 3000) begin
      if (cd == 2) chk("extra_gap", blk_valid, 1'b0);
      if (cd == 1) chk("latency", blk_valid, 1'b1);
      if (cd > 0) cd--;
      in_valid = (idx < msg_q.size()) && (mode != 1 || $urandom_range(3) != 0);
      in_data  = in_valid ? msg_q[idx] : 8'($urandom);
      in_last  = in_valid ? (idx == msg_q.size() - 1) : 1'($urandom);
      case (mode)
        0:       blk_ready = 1'b1;
        1:       blk_ready = 1'($urandom);
        default: blk_ready = (stall >= 5);
      endcase
      if (blk_valid) begin
        chk("emit_in_ready", in_ready, 1'b0);
        chk("blk_data", blk_data, exp_blk[got]);
        chk("blk_first", blk_first, exp_first[got]);
        chk("blk_last", blk_last, exp_last[got]);
        if (!blk_ready) stall++;
      end
      bx = in_valid && in_ready;
      kx = blk_valid && blk_ready;
      @(posedge clk);
      if (bx) begin
        idx++;
        if (idx == msg_q.size() || idx % 64 == 0) cd = 1;
      end
      if (kx) begin
        got++;
        if (got < exp_blk.size() && idx == msg_q.size()) cd = 2;
      end
      @(negedge clk);
      cyc++;
    end
    chk("block_count", got, exp_blk.size());
    in_valid  = 1'b0;
    blk_ready = 1'b0;
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; blk_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_data", blk_data, 512'd0);
    chk("rst_blk_first", blk_first, 1'b1);
    chk("rst_blk_last", blk_last, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(0);
    msg_q.delete();
    for (int i = 0; i < 55; i++) msg_q.push_back(8'h00);
    run_msg(0);
    rand_msg(56);  run_msg(0);
    rand_msg(64);  run_msg(0);
    rand_msg(20);  run_msg(2);
    rand_msg(100); run_msg(2);
    for (int m = 0; m < 6; m++) begin
      rand_msg($urandom_range(150, 1));
      run_msg(1);
    end

    // reset mid-message after 30 bytes, then "abc"
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_blk_valid", blk_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(0);

    // reset while a block waits in EMIT
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = (i == 9);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("held_blk_valid", blk_valid, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("emitrst_blk_valid", blk_valid, 1'b0);
    chk("emitrst_blk_first", blk_first, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rand_msg(57); run_msg(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
